// File: rtl/axi4_lite_gpio_slave_pkg.sv
// Shared AXI4-Lite definitions: response codes, register indices and the
// byte-strobe merge helper used by the GPIO register slave.
package axi4_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Word indices of the register file (index = addr[ADDRESS_WIDTH-1:2]).
  localparam int REG_GPIO_DATA = 0;
  localparam int REG_GPIO_TRI  = 1;
  localparam int REG_SCRATCH   = 2;
  localparam int REG_ID        = 3;
  localparam int NUM_REGS      = 4;

  // Replace each byte lane of old_value whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_value,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = old_value;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_gpio_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
//
// Handshake rule for every channel (AW, W, B, AR, R): a transfer happens on
// the rising clock edge where valid and ready are both high. Once valid is
// raised its payload stays stable and valid stays high until that edge.
// The slave drives its ready signals from registers only, never
// combinationally from the master's valid.
interface axi4_lite_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) ();
  import axi4_lite_pkg::*;

  logic [ADDRESS_WIDTH-1:0]  s_axi_awaddr;
  logic                      s_axi_awvalid;
  logic                      s_axi_awready;
  logic [DATA_WIDTH-1:0]     s_axi_wdata;
  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb;
  logic                      s_axi_wvalid;
  logic                      s_axi_wready;
  resp_t                     s_axi_bresp;
  logic                      s_axi_bvalid;
  logic                      s_axi_bready;
  logic [ADDRESS_WIDTH-1:0]  s_axi_araddr;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [DATA_WIDTH-1:0]     s_axi_rdata;
  resp_t                     s_axi_rresp;
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

endinterface

// File: rtl/axi4_lite_gpio_slave.sv
// AXI4-Lite GPIO/scratch register slave. Four word registers (GPIO_DATA,
// GPIO_TRI, SCRATCH, read-only ID); one outstanding transaction per
// channel; byte strobes honoured; SLVERR for ID writes and out-of-range
// accesses. gpio_o/gpio_t mirror GPIO_DATA/GPIO_TRI.
module axi4_lite_gpio_slave
  import axi4_lite_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDRESS_WIDTH = 32,
  parameter logic [31:0] GPIO_RESET    = 32'h0000_0000,
  parameter logic [31:0] TRI_RESET     = 32'hFFFF_FFFF,
  parameter logic [31:0] ID_VALUE      = 32'h4750_494F
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi4_lite_if.slave            s_axi,
  output logic [DATA_WIDTH-1:0] gpio_o,
  output logic [DATA_WIDTH-1:0] gpio_t
);

  // Only a 32-bit data path and at least a 16-byte address window make sense.
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi4_lite_gpio_slave: DATA_WIDTH must be 32");
  end
  if (ADDRESS_WIDTH < 4) begin : g_bad_addr_width
    $error("axi4_lite_gpio_slave: ADDRESS_WIDTH must be >= 4");
  end

  localparam logic [1:0] IDX_DATA    = 2'(REG_GPIO_DATA);
  localparam logic [1:0] IDX_TRI     = 2'(REG_GPIO_TRI);
  localparam logic [1:0] IDX_SCRATCH = 2'(REG_SCRATCH);
  localparam logic [1:0] IDX_ID      = 2'(REG_ID);

  // Register file
  logic [31:0] gpio_data;
  logic [31:0] gpio_tri;
  logic [31:0] scratch;

  // Write channel state
  logic        awready_q;
  logic        wready_q;
  logic        aw_pend;
  logic        w_pend;
  logic [1:0]  aw_idx;
  logic        aw_in_range;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        bvalid_q;
  resp_t       bresp_q;

  // Read channel state
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  resp_t       rresp_q;

  // Address decode of the incoming AW/AR addresses. Byte-offset bits [1:0]
  // are ignored; any set bit above [3:2] means the word index is >= 4.
  logic [1:0] awaddr_idx;
  logic [1:0] araddr_idx;
  logic       awaddr_in_range;
  logic       araddr_in_range;
  logic       unused_addr_bits;

  assign awaddr_idx       = s_axi.s_axi_awaddr[3:2];
  assign araddr_idx       = s_axi.s_axi_araddr[3:2];
  assign unused_addr_bits = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  if (ADDRESS_WIDTH > 4) begin : g_hi_decode
    assign awaddr_in_range = (s_axi.s_axi_awaddr[ADDRESS_WIDTH-1:4] == '0);
    assign araddr_in_range = (s_axi.s_axi_araddr[ADDRESS_WIDTH-1:4] == '0);
  end else begin : g_no_hi_decode
    assign awaddr_in_range = 1'b1;
    assign araddr_in_range = 1'b1;
  end

  // Write channel next-state terms; the ready outputs are registered from
  // the next values so they never depend combinationally on valid inputs.
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic commit;
  logic write_legal;
  logic aw_pend_nxt;
  logic w_pend_nxt;
  logic bvalid_nxt;

  // Derive handshakes and the next pending/response flags.
  always_comb begin
    aw_hs       = s_axi.s_axi_awvalid && awready_q;
    w_hs        = s_axi.s_axi_wvalid && wready_q;
    b_hs        = bvalid_q && s_axi.s_axi_bready;
    commit      = aw_pend && w_pend;
    write_legal = aw_in_range && (aw_idx != IDX_ID);
    aw_pend_nxt = aw_pend;
    w_pend_nxt  = w_pend;
    bvalid_nxt  = bvalid_q;
    if (commit) begin
      aw_pend_nxt = 1'b0;
      w_pend_nxt  = 1'b0;
      bvalid_nxt  = 1'b1;
    end else begin
      if (aw_hs) aw_pend_nxt = 1'b1;
      if (w_hs)  w_pend_nxt  = 1'b1;
      if (b_hs)  bvalid_nxt  = 1'b0;
    end
  end

  // Write path: capture AW/W independently, commit once both are held,
  // then hold the B response until the master takes it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      aw_idx      <= '0;
      aw_in_range <= 1'b0;
      w_data      <= '0;
      w_strb      <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      gpio_data   <= GPIO_RESET;
      gpio_tri    <= TRI_RESET;
      scratch     <= '0;
    end else begin
      aw_pend   <= aw_pend_nxt;
      w_pend    <= w_pend_nxt;
      bvalid_q  <= bvalid_nxt;
      awready_q <= !aw_pend_nxt && !bvalid_nxt;
      wready_q  <= !w_pend_nxt && !bvalid_nxt;
      if (aw_hs) begin
        aw_idx      <= awaddr_idx;
        aw_in_range <= awaddr_in_range;
      end
      if (w_hs) begin
        w_data <= s_axi.s_axi_wdata;
        w_strb <= s_axi.s_axi_wstrb;
      end
      if (commit) begin
        // An all-zero strobe merges nothing, so it falls out as an OKAY no-op.
        bresp_q <= write_legal ? RESP_OKAY : RESP_SLVERR;
        if (write_legal) begin
          case (aw_idx)
            IDX_DATA:    gpio_data <= strb_merge(gpio_data, w_data, w_strb);
            IDX_TRI:     gpio_tri  <= strb_merge(gpio_tri, w_data, w_strb);
            IDX_SCRATCH: scratch   <= strb_merge(scratch, w_data, w_strb);
            default:     ;
          endcase
        end
      end else if (b_hs) begin
        bresp_q <= RESP_OKAY;
      end
    end
  end

  // Read data mux; it sees the registers' current values, so a read that
  // handshakes on a commit edge returns the pre-write contents.
  logic [31:0] rd_value;
  resp_t       rd_resp;

  // Select read data and response for the presented AR address.
  always_comb begin
    rd_value = '0;
    rd_resp  = RESP_SLVERR;
    if (araddr_in_range) begin
      rd_resp = RESP_OKAY;
      case (araddr_idx)
        IDX_DATA:    rd_value = gpio_data;
        IDX_TRI:     rd_value = gpio_tri;
        IDX_SCRATCH: rd_value = scratch;
        default:     rd_value = ID_VALUE;
      endcase
    end
  end

  // Read path: one-cycle AR-to-R latency, R held until rready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (s_axi.s_axi_arvalid && arready_q) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rd_value;
      rresp_q   <= rd_resp;
    end else if (rvalid_q && s_axi.s_axi_rready) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= !rvalid_q;
    end
  end

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;

  assign gpio_o = gpio_data;
  assign gpio_t = gpio_tri;

endmodule

// File: tb/tb_axi4_lite_gpio_slave.sv
// Bench for axi4_lite_gpio_slave: directed scenarios plus randomized
// traffic, with expected B/R responses queued at issue time and compared
// by a separate negedge monitor.
module tb_axi4_lite_gpio_slave;
  import axi4_lite_pkg::*;

  localparam logic [31:0] GPIO_RST = 32'h0000_0000;
  localparam logic [31:0] TRI_RST  = 32'hFFFF_FFFF;
  localparam logic [31:0] ID_VAL   = 32'h4750_494F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gpio_o;
  logic [31:0] gpio_t;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  axi4_lite_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_gpio_slave #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .GPIO_RESET(GPIO_RST),
    .TRI_RESET(TRI_RST), .ID_VALUE(ID_VAL)
  ) dut (
    .aclk(clk), .aresetn(rst_n), .s_axi(bus), .gpio_o(gpio_o), .gpio_t(gpio_t)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a B or R beat completes on the next posedge when valid&&ready.
  always @(negedge clk) begin
    if (rst_n && bus.s_axi_bvalid && bus.s_axi_bready) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bresp %0h expected no response", bus.s_axi_bresp);
      end else begin
        check("bresp", bus.s_axi_bresp, exp_b_q.pop_front());
      end
    end
    if (rst_n && bus.s_axi_rvalid && bus.s_axi_rready) begin
      if (exp_r_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got %0h expected no response", bus.s_axi_rdata);
      end else begin
        check("rresp_rdata", {bus.s_axi_rresp, bus.s_axi_rdata}, exp_r_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  // Registers 0..2 are read/write; word 3 is the constant ID; anything else
  // is outside the map.
  logic [31:0] m_regs[3];

  task automatic model_reset();
    m_regs[0] = GPIO_RST;
    m_regs[1] = TRI_RST;
    m_regs[2] = 32'h0;
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int widx;
    widx = (addr[31:4] != 0) ? 99 : int'(addr[3:2]);
    if (widx > 2) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (strb[b]) m_regs[widx][8*b +: 8] = data[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    int widx;
    widx = (addr[31:4] != 0) ? 99 : int'(addr[3:2]);
    if (widx <= 2) return {2'b00, m_regs[widx]};
    if (widx == 3) return {2'b00, ID_VAL};
    return {2'b10, 32'h0};
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end 1ns after a rising edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_hold);
    int aw_hs = 0, w_hs = 0, last_hs;
    bit ok_aw = 0, ok_w = 0, seen = 0;
    fork
      begin
        repeat (aw_dly) @(posedge clk);
        if (aw_dly > 0) #1;
        bus.s_axi_awaddr = addr; bus.s_axi_awvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (bus.s_axi_awready) begin aw_hs = cyc + 1; ok_aw = 1; break; end
        end
        if (ok_aw) begin @(posedge clk); #1; end
        bus.s_axi_awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(posedge clk);
        if (w_dly > 0) #1;
        bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (bus.s_axi_wready) begin w_hs = cyc + 1; ok_w = 1; break; end
        end
        if (ok_w) begin @(posedge clk); #1; end
        bus.s_axi_wvalid = 1'b0;
      end
    join
    check("aw_accepted", ok_aw, 1'b1);
    check("w_accepted", ok_w, 1'b1);
    if (!(ok_aw && ok_w)) return;
    last_hs = (aw_hs > w_hs) ? aw_hs : w_hs;
    exp_b_q.push_back(model_write(addr, data, strb));
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.s_axi_bvalid) begin seen = 1; break; end
    end
    check("bvalid_seen", seen, 1'b1);
    if (!seen) begin void'(exp_b_q.pop_back()); return; end
    check("b_latency", cyc, last_hs + 1);
    for (int i = 0; i < b_hold; i++) begin
      check("bvalid_held", bus.s_axi_bvalid, 1'b1);
      check("awready_blocked", {bus.s_axi_awready, bus.s_axi_wready}, 2'b00);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.s_axi_bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bus.s_axi_bready = 1'b0;
    @(negedge clk);
    check("gpio_o", gpio_o, m_regs[0]);
    check("gpio_t", gpio_t, m_regs[1]);
    check("b_cleared", bus.s_axi_bvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_hold);
    logic [33:0] exp;
    bit ok = 0;
    exp = model_read(addr);
    exp_r_q.push_back(exp);
    bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.s_axi_arready) begin ok = 1; break; end
    end
    check("ar_accepted", ok, 1'b1);
    if (ok) begin @(posedge clk); #1; end
    bus.s_axi_arvalid = 1'b0;
    if (!ok) begin void'(exp_r_q.pop_back()); return; end
    @(negedge clk);
    check("r_latency", bus.s_axi_rvalid, 1'b1);
    for (int i = 0; i < r_hold; i++) begin
      check("rvalid_held", bus.s_axi_rvalid, 1'b1);
      check("arready_low", bus.s_axi_arready, 1'b0);
      check("rdata_held", bus.s_axi_rdata, exp[31:0]);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.s_axi_rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bus.s_axi_rready = 1'b0;
    @(negedge clk);
    check("r_cleared", {bus.s_axi_rvalid, bus.s_axi_arready}, 2'b01);
    @(posedge clk); #1;
  endtask

  // Write commit and AR handshake land on the same edge to SCRATCH.
  task automatic same_edge_rw(input logic [31:0] data);
    bit ok = 0;
    bus.s_axi_awaddr = 32'h8; bus.s_axi_wdata = data; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.s_axi_awready && bus.s_axi_wready) begin ok = 1; break; end
    end
    check("same_edge_aw_w", ok, 1'b1);
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_araddr = 32'h8; bus.s_axi_arvalid = 1'b1;
    exp_r_q.push_back(model_read(32'h8));
    exp_b_q.push_back(model_write(32'h8, data, 4'hF));
    @(negedge clk);
    check("same_edge_arready", bus.s_axi_arready, 1'b1);
    @(posedge clk); #1 bus.s_axi_arvalid = 1'b0;
    @(negedge clk);
    check("same_edge_valids", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 2'b11);
    @(posedge clk); #1 bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] addr;
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0; bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    model_reset();

    // Reset state
    #22;
    check("rst_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
    check("rst_valids", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 2'b00);
    check("rst_rdata", bus.s_axi_rdata, 32'h0);
    check("rst_gpio_o", gpio_o, GPIO_RST);
    check("rst_gpio_t", gpio_t, TRI_RST);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
    @(posedge clk); #1;
    axi_read(32'hC, 0);

    // Directed traffic
    axi_write(32'h0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_write(32'h8, 32'h1234_5678, 4'b0101, 3, 0, 4);
    axi_read(32'h8, 0);
    axi_write(32'hC, 32'h1111_2222, 4'hF, 0, 1, 0);
    axi_write(32'h10, 32'h3333_4444, 4'hF, 2, 0, 1);
    axi_read(32'hC, 0);
    axi_read(32'h10, 0);
    axi_read(32'h4, 3);
    axi_read(32'h4, 3);
    axi_write(32'h0, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    axi_read(32'h0, 1);
    same_edge_rw(32'h0BAD_F00D);
    axi_read(32'h8, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      addr = (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h4000_0000;
      if ($urandom_range(0, 1) == 0) begin
        axi_write(addr, $urandom(),
                  (addr[31:4] == 0 && addr[3:2] != 2'd3) ? 4'($urandom_range(0, 15))
                                                           : 4'($urandom_range(1, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        axi_read(addr, $urandom_range(0, 3));
      end
    end

    // Reset while a B response is outstanding
    bus.s_axi_awaddr = 32'h8; bus.s_axi_wdata = 32'hA5A5_1234; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    @(negedge clk);
    check("pre_rst_ready", {bus.s_axi_awready, bus.s_axi_wready}, 2'b11);
    @(posedge clk); #1 bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_bvalid", bus.s_axi_bvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", bus.s_axi_bvalid, 1'b0);
    check("mid_rst_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
    check("mid_rst_gpio_o", gpio_o, GPIO_RST);
    check("mid_rst_gpio_t", gpio_t, TRI_RST);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1 bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_resp", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 2'b00);
    end
    @(posedge clk); #1 bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    axi_read(32'h8, 0);
    axi_read(32'h0, 0);

    // Report
    repeat (2) @(posedge clk);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_gpio_slave.md
Name: axi4_lite_gpio_slave

Overview:
AXI4-Lite responder for the AXI4-Lite master with LUT. It presents a 4-register GPIO/scratch register file and drives a GPIO output bus. It replaces the vendor GPIO block design in self-contained benches and in fabric builds. Each channel allows a single outstanding transaction, with full byte-strobe support and SLVERR on illegal accesses.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported (elaboration error otherwise).
ADDRESS_WIDTH, 32, address bus width; must be ≥ 4.
GPIO_RESET, 32'h0000_0000, reset value of GPIO_DATA.
TRI_RESET, 32'hFFFF_FFFF, reset value of GPIO_TRI (1 = input/high-Z).
ID_VALUE, 32'h4750_494F, constant returned by the ID register.

Ports:
aclk  in  1  clock; all logic is on the rising edge.
aresetn  in  1  asynchronous active-low reset.
s_axi_awaddr  in  ADDRESS_WIDTH  write address.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address ready.
s_axi_wdata  in  DATA_WIDTH  write data.
s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data ready.
s_axi_bresp  out  2  write response.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
s_axi_araddr  in  ADDRESS_WIDTH  read address.
s_axi_arvalid  in  1  read address valid.
s_axi_arready  out  1  read address ready.
s_axi_rdata  out  DATA_WIDTH  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data ready.
gpio_o  out  DATA_WIDTH  GPIO_DATA register.
gpio_t  out  DATA_WIDTH  GPIO_TRI register.

Behaviour:
- Register map (word index = addr[ADDRESS_WIDTH-1:2]; addr[1:0] ignored):
  - 0 GPIO_DATA: RW.
  - 1 GPIO_TRI: RW.
  - 2 SCRATCH: RW, resets to 0.
  - 3 ID: RO.
  - Index ≥ 4 is out of range.
- Reset (async assert, sync release):
  - awready = wready = arready = 0 while aresetn = 0; all become 1 on the first edge after release.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.
  - Registers load their reset values; gpio_o = GPIO_RESET; gpio_t = TRI_RESET.
- Write path:
  - AW and W are captured independently into holding regs with aw_pend / w_pend flags.
  - awready = !aw_pend && !bvalid; wready = !w_pend && !bvalid. Registered, never combinational from valid inputs.
  - When aw_pend && w_pend at edge k+1: commit the write, clear both flags, set bvalid.
  - Latency: both channels handshake at edge k → register updated and bvalid=1 after edge k+1. AW and W may arrive in any order or cycle separation.
- Commit rules:
  - Per-byte merge: new[8i+7:8i] = wstrb[i] ? wdata : old.
  - In-range RW register → bresp OKAY (2'b00).
  - ID or out-of-range → no state change, bresp SLVERR (2'b10).
  - wstrb = 0 → no change, bresp OKAY.
- bvalid/bresp are held until bready; they clear on the bvalid && bready edge. New AW/W acceptance resumes the following cycle.
- Read path:
  - arready = !rvalid.
  - AR handshake at edge k → rvalid=1 with rdata/rresp registered after edge k (1-cycle latency).
  - Out-of-range read → rdata 0, SLVERR.
  - rvalid/rdata/rresp are stable until rready; they clear on the handshake edge.
- Simultaneous read and write commit to the same register at the same edge: the read returns the pre-write value.
- gpio_o / gpio_t change on the commit edge only.
- Reset mid-transaction: pending AW/W and outstanding B/R responses are dropped; no response is issued after reset.

Decomposition:
- Shared package axi4_lite_pkg contains:
  - resp_t (2-bit) and constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Register index constants REG_GPIO_DATA = 0, REG_GPIO_TRI = 1, REG_SCRATCH = 2, REG_ID = 3, NUM_REGS = 4.
  - Function strb_merge(old, wdata, wstrb).
- No sub-module; write and read channels are two always_ff blocks in one module.

Test Plan:
- Reset release → after first edge awready = wready = arready = 1; gpio_o = 0; gpio_t = FFFFFFFF; read idx 3 → rdata 4750494F, OKAY.
- AW 0x0 and W DEADBEEF (wstrb F) in the same cycle → bvalid after 1 more edge, bresp 00, gpio_o = DEADBEEF.
- W 0x12345678 (wstrb 0101) three cycles before AW 0x8, bready held low 4 cycles → bvalid stays high with bresp 00; readback 0x8 → 00340078.
- Write to 0xC and to 0x10 → bresp 10 each, ID unchanged; read 0x10 → rdata 0, rresp 10.
- Back-to-back reads of 0x4 with rready low 3 cycles → rvalid and rdata FFFFFFFF held, arready = 0 until the handshake.
- Write AW/W to 0x8 accepted, then aresetn low before bready → bvalid = 0 immediately, SCRATCH = 0, no B response after release.
